// File: rtl/pool_window_sequencer.sv
// Sequencer that drives a combinational 2x2 average-pooling core: fetches each
// stride-2 window from a sync-read buffer, hands it to the core, writes the result.
module pool_window_sequencer #(
  parameter int IMG_W = 4,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [15:0]   rd_data,
  output logic [399:0]  win_flat,
  output logic          pool_start,
  input  logic          pool_finish,
  input  logic [15:0]   pool_pixel,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data
);

  localparam int OW = IMG_W / 2;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPT, S_POOL, S_WRITE, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    k_q, k_d;
  logic [AW-1:0] orow_q, orow_d, ocol_q, ocol_d;
  logic [15:0]   w00_q, w00_d, w01_q, w01_d, w10_q, w10_d, w11_q, w11_d;
  logic [15:0]   wr_data_q, wr_data_d;

  logic [AW-1:0] row, col, out_idx;
  logic          last_out;

  // Pixel coordinate of the current fetch: k[1] selects the row, k[0] the column.
  always_comb begin
    row      = {orow_q[AW-2:0], 1'b0} + {{(AW-1){1'b0}}, k_q[1]};
    col      = {ocol_q[AW-2:0], 1'b0} + {{(AW-1){1'b0}}, k_q[0]};
    out_idx  = AW'(orow_q * AW'(OW) + ocol_q);
    last_out = (orow_q == AW'(OW - 1)) && (ocol_q == AW'(OW - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      orow_q    <= '0;
      ocol_q    <= '0;
      w00_q     <= '0;
      w01_q     <= '0;
      w10_q     <= '0;
      w11_q     <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      orow_q    <= orow_d;
      ocol_q    <= ocol_d;
      w00_q     <= w00_d;
      w01_q     <= w01_d;
      w10_q     <= w10_d;
      w11_q     <= w11_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    orow_d    = orow_q;
    ocol_d    = ocol_q;
    w00_d     = w00_q;
    w01_d     = w01_q;
    w10_d     = w10_q;
    w11_d     = w11_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_FETCH;
          k_d     = '0;
          orow_d  = '0;
          ocol_d  = '0;
        end
      end
      S_FETCH: begin
        k_d = k_q + 2'd1;
        // Read data lags the strobe by one cycle, so step k lands element k-1.
        case (k_q)
          2'd1:    w00_d = rd_data;
          2'd2:    w01_d = rd_data;
          2'd3:    w10_d = rd_data;
          default: ;
        endcase
        if (k_q == 2'd3) state_d = S_CAPT;
      end
      S_CAPT: begin
        w11_d   = rd_data;
        state_d = S_POOL;
      end
      S_POOL: begin
        if (pool_finish) begin
          wr_data_d = pool_pixel;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        k_d = '0;
        if (last_out) begin
          orow_d  = '0;
          ocol_d  = '0;
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
          if (ocol_q == AW'(OW - 1)) begin
            ocol_d = '0;
            orow_d = orow_q + AW'(1);
          end else begin
            ocol_d = ocol_q + AW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign rd_en      = (state_q == S_FETCH);
  assign rd_addr    = rd_en ? AW'(row * AW'(IMG_W) + col) : '0;
  assign pool_start = (state_q == S_POOL);
  assign wr_en      = (state_q == S_WRITE);
  assign wr_addr    = wr_en ? out_idx : '0;
  assign wr_data    = wr_data_q;

  always_comb begin
    win_flat          = '0;
    win_flat[0*16+:16] = w00_q;
    win_flat[1*16+:16] = w01_q;
    win_flat[5*16+:16] = w10_q;
    win_flat[6*16+:16] = w11_q;
  end

endmodule
